// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the prefetch issue queue.
package prefetch_pkg;

    localparam int unsigned PF_ADDR_W = 32;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        THROTTLE
    } issue_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pf_sync_fifo.sv
// Synchronous FIFO with separate occupancy count and a registered head output.
module pf_sync_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [FCNT_W-1:0] count_o,
    output logic [FCNT_W-1:0] count_next_o,
    output logic [ADDR_W-1:0] head_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != FCNT_W'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + FCNT_W'(do_push) - FCNT_W'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        head_d = head_q;
        // The next head may be the entry being written this very cycle.
        if (count_d != '0) begin
            head_d = (do_push && (rd_ptr_d == wr_ptr_q)) ? data_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign full_o       = (count_q == FCNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_o       = head_q;

endmodule

// File: rtl/prefetch_issue_queue.sv
// Captures prefetcher addresses, filters recent duplicates, queues survivors and
// issues them as memory reads with a cap on outstanding requests.
module prefetch_issue_queue
    import prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W          = PF_ADDR_W,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned FILTER_ENTRIES  = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pf_addr_i,
    input  logic              pf_valid_i,
    input  logic              flush_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    output logic [CNT_W-1:0]  dup_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [OUT_W-1:0]  outstanding_o,
    output logic              rsp_err_o,
    output logic              idle_o
);

    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    issue_state_t            state_q, state_d;
    logic [OUT_W-1:0]        out_q, out_d;
    logic [CNT_W-1:0]        dup_q, dup_d, drop_q, drop_d;
    logic                    err_q, err_d;
    logic [ADDR_W-1:0]       filt_addr_q [FILTER_ENTRIES];
    logic [ADDR_W-1:0]       filt_addr_d [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] filt_vld_q, filt_vld_d;

    logic              capture, filt_hit, push, fire, rsp_ok;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count, fifo_count_next;

    assign mem_req_valid_o = (state_q == ISSUE);
    assign idle_o          = (state_q == IDLE);
    assign fire            = mem_req_valid_o && mem_req_ready_i;
    assign capture         = pf_valid_i && !flush_i;
    assign push            = capture && !filt_hit && !fifo_full;
    assign rsp_ok          = mem_rsp_valid_i && (out_q != '0);

    pf_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .flush_i      (flush_i),
        .push_i       (push),
        .data_i       (pf_addr_i),
        .pop_i        (fire),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .head_o       (mem_req_addr_o)
    );

    always_comb begin
        filt_hit = 1'b0;
        for (int i = 0; i < int'(FILTER_ENTRIES); i++) begin
            if (filt_vld_q[i] && (filt_addr_q[i] == pf_addr_i)) filt_hit = 1'b1;
        end
    end

    always_comb begin
        out_d  = out_q + OUT_W'(fire) - OUT_W'(rsp_ok);
        err_d  = err_q | (mem_rsp_valid_i && (out_q == '0));
        dup_d  = (capture && filt_hit) ? sat_inc(dup_q) : dup_q;
        drop_d = (capture && !filt_hit && fifo_full) ? sat_inc(drop_q) : drop_q;

        filt_addr_d = filt_addr_q;
        filt_vld_d  = filt_vld_q;
        if (flush_i) begin
            filt_vld_d = '0;
        end else if (push) begin
            for (int i = int'(FILTER_ENTRIES) - 1; i > 0; i--) begin
                filt_addr_d[i] = filt_addr_q[i-1];
            end
            filt_addr_d[0] = pf_addr_i;
            filt_vld_d     = {filt_vld_q[FILTER_ENTRIES-2:0], 1'b1};
        end

        // Throttle takes priority so a full window never shows a valid request.
        if (out_d == OUT_W'(MAX_OUTSTANDING)) begin
            state_d = THROTTLE;
        end else if (fifo_count_next != '0) begin
            state_d = ISSUE;
        end else if (out_d != '0) begin
            state_d = WAIT_RSP;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q      <= '0;
            err_q      <= 1'b0;
            dup_q      <= '0;
            drop_q     <= '0;
            filt_vld_q <= '0;
            for (int i = 0; i < int'(FILTER_ENTRIES); i++) filt_addr_q[i] <= '0;
        end else begin
            out_q       <= out_d;
            err_q       <= err_d;
            dup_q       <= dup_d;
            drop_q      <= drop_d;
            filt_vld_q  <= filt_vld_d;
            filt_addr_q <= filt_addr_d;
        end
    end

    assign dup_cnt_o     = dup_q;
    assign drop_cnt_o    = drop_q;
    assign outstanding_o = out_q;
    assign rsp_err_o     = err_q;

endmodule
